// File: rtl/bp_me_clint_slice_pkg.sv
// Shared definitions for the CLINT endpoint: register offsets, FSM states and
// the BedRock message type/size encodings it understands.
package bp_me_clint_slice_pkg;

  localparam logic [15:0] clint_msip_offset_gp     = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_offset_gp = 16'h4000;
  localparam logic [15:0] clint_mtime_offset_gp    = 16'hBFF8;

  typedef enum logic {
    e_ready = 1'b0,
    e_resp  = 1'b1
  } clint_state_e;

  typedef enum logic [1:0] {
    e_bedrock_mem_rd = 2'b00,
    e_bedrock_mem_wr = 2'b01
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_4 = 3'b010,
    e_bedrock_msg_size_8 = 3'b011
  } bp_bedrock_msg_size_e;

endpackage

// File: rtl/bp_me_clint_slice_if.sv
// BedRock memory forward/reverse channel as seen by the CLINT endpoint.
interface bp_me_clint_slice_if #(
  parameter int paddr_width_p = 40
) ();

  logic                     mem_fwd_v_i;
  logic                     mem_fwd_ready_and_o;
  logic [1:0]               mem_fwd_msg_type_i;
  logic [paddr_width_p-1:0] mem_fwd_addr_i;
  logic [2:0]               mem_fwd_size_i;
  logic [63:0]              mem_fwd_data_i;

  logic                     mem_rev_v_o;
  logic                     mem_rev_ready_and_i;
  logic [1:0]               mem_rev_msg_type_o;
  logic [paddr_width_p-1:0] mem_rev_addr_o;
  logic [2:0]               mem_rev_size_o;
  logic [63:0]              mem_rev_data_o;

  modport slave (
    input  mem_fwd_v_i, mem_fwd_msg_type_i, mem_fwd_addr_i, mem_fwd_size_i,
           mem_fwd_data_i, mem_rev_ready_and_i,
    output mem_fwd_ready_and_o, mem_rev_v_o, mem_rev_msg_type_o,
           mem_rev_addr_o, mem_rev_size_o, mem_rev_data_o
  );

  modport master (
    output mem_fwd_v_i, mem_fwd_msg_type_i, mem_fwd_addr_i, mem_fwd_size_i,
           mem_fwd_data_i, mem_rev_ready_and_i,
    input  mem_fwd_ready_and_o, mem_rev_v_o, mem_rev_msg_type_o,
           mem_rev_addr_o, mem_rev_size_o, mem_rev_data_o
  );

endinterface

// File: rtl/bp_me_clint_rtc_sync.sv
// Brings the asynchronous RTC into the core clock domain and emits a single
// clock-wide pulse per RTC rising edge.
module bp_me_clint_rtc_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rtc_i,
  output logic tick_o
);

  logic rtc_p0, rtc_p1, rtc_p2;

  // p0/p1 resolve metastability, p2 holds the previous level for edge detect
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rtc_p0 <= 1'b0;
      rtc_p1 <= 1'b0;
      rtc_p2 <= 1'b0;
    end else begin
      rtc_p0 <= rtc_i;
      rtc_p1 <= rtc_p0;
      rtc_p2 <= rtc_p1;
    end
  end

  assign tick_o = rtc_p1 & ~rtc_p2;

endmodule

// File: rtl/bp_me_clint_slice.sv
// CLINT endpoint for one core: msip/mtimecmp/mtime behind a BedRock memory
// port, one response per request, plus timer and software interrupt lines.
module bp_me_clint_slice
  import bp_me_clint_slice_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      rtc_i,
  bp_me_clint_slice_if.slave        mem_if,
  output logic                      timer_irq_o,
  output logic                      software_irq_o,
  output logic [63:0]               mtime_o
);

  if (data_width_p != 64) begin : g_bad_data_width
    $error("bp_me_clint_slice supports only data_width_p = 64");
  end

  clint_state_e             state_r;
  logic                     fwd_ready_r;
  logic                     rev_v_r;
  logic [1:0]               rev_type_r;
  logic [paddr_width_p-1:0] rev_addr_r;
  logic [2:0]               rev_size_r;
  logic [63:0]              rev_data_r;

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        msip_r;
  logic        timer_irq_r;
  logic        tick;

  logic        fwd_hs;
  logic        is_wr;
  logic        is_rd;
  logic        is_4b;
  logic        upper_half;
  logic [15:0] word_off;
  logic        hit_msip, hit_mtimecmp, hit_mtime;
  logic [63:0] wr_mask, wr_data, rd_reg, rd_data;
  logic [63:0] msip_next;

  function automatic logic [63:0] merge_write(input logic [63:0] old_val,
                                              input logic [63:0] data,
                                              input logic [63:0] mask);
    return (old_val & ~mask) | (data & mask);
  endfunction

  // Narrow reads return the chosen half copied into both halves
  function automatic logic [63:0] read_view(input logic [63:0] val,
                                            input logic        narrow,
                                            input logic        upper);
    logic [31:0] half;
    half = upper ? val[63:32] : val[31:0];
    return narrow ? {half, half} : val;
  endfunction

  bp_me_clint_rtc_sync u_rtc_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .rtc_i   (rtc_i),
    .tick_o  (tick)
  );

  assign fwd_hs = fwd_ready_r & mem_if.mem_fwd_v_i;

  always_comb begin
    is_wr        = (mem_if.mem_fwd_msg_type_i == e_bedrock_mem_wr);
    is_rd        = (mem_if.mem_fwd_msg_type_i == e_bedrock_mem_rd);
    is_4b        = (mem_if.mem_fwd_size_i == e_bedrock_msg_size_4);
    upper_half   = mem_if.mem_fwd_addr_i[2];
    word_off     = {mem_if.mem_fwd_addr_i[15:3], 3'b000};
    hit_msip     = (word_off == clint_msip_offset_gp);
    hit_mtimecmp = (word_off == clint_mtimecmp_offset_gp);
    hit_mtime    = (word_off == clint_mtime_offset_gp);

    wr_mask = '1;
    if (is_4b) begin
      wr_mask = upper_half ? {32'hFFFF_FFFF, 32'h0000_0000}
                           : {32'h0000_0000, 32'hFFFF_FFFF};
    end
    wr_data = is_4b ? {2{mem_if.mem_fwd_data_i[31:0]}} : mem_if.mem_fwd_data_i;

    rd_reg = '0;
    if (hit_msip)     rd_reg = {63'b0, msip_r};
    if (hit_mtimecmp) rd_reg = mtimecmp_r;
    if (hit_mtime)    rd_reg = mtime_r;
    // Writes and unsupported types answer with zero data
    rd_data = is_rd ? read_view(rd_reg, is_4b, upper_half) : '0;

    msip_next = merge_write({63'b0, msip_r}, wr_data, wr_mask);
  end

  // Handshake FSM: one outstanding request, response held until accepted
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r     <= e_ready;
      fwd_ready_r <= 1'b1;
      rev_v_r     <= 1'b0;
    end else begin
      case (state_r)
        e_ready: begin
          if (fwd_hs) begin
            state_r     <= e_resp;
            fwd_ready_r <= 1'b0;
            rev_v_r     <= 1'b1;
          end
        end
        e_resp: begin
          if (mem_if.mem_rev_ready_and_i) begin
            state_r     <= e_ready;
            fwd_ready_r <= 1'b1;
            rev_v_r     <= 1'b0;
          end
        end
        default: begin
          state_r     <= e_ready;
          fwd_ready_r <= 1'b1;
          rev_v_r     <= 1'b0;
        end
      endcase
    end
  end

  // Response payload: captured at the forward handshake, no reset needed
  always_ff @(posedge clk_i) begin
    if (fwd_hs) begin
      rev_type_r <= mem_if.mem_fwd_msg_type_i;
      rev_addr_r <= mem_if.mem_fwd_addr_i;
      rev_size_r <= mem_if.mem_fwd_size_i;
      rev_data_r <= rd_data;
    end
  end

  // Architectural registers; an mtime write wins over a coincident tick
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      msip_r      <= 1'b0;
      mtimecmp_r  <= '1;
      mtime_r     <= '0;
      timer_irq_r <= 1'b0;
    end else begin
      if (fwd_hs && is_wr && hit_msip)
        msip_r <= msip_next[0];
      if (fwd_hs && is_wr && hit_mtimecmp)
        mtimecmp_r <= merge_write(mtimecmp_r, wr_data, wr_mask);
      if (fwd_hs && is_wr && hit_mtime)
        mtime_r <= merge_write(mtime_r, wr_data, wr_mask);
      else if (tick)
        mtime_r <= mtime_r + 64'd1;
      timer_irq_r <= (mtime_r >= mtimecmp_r);
    end
  end

  assign mem_if.mem_fwd_ready_and_o = fwd_ready_r;
  assign mem_if.mem_rev_v_o         = rev_v_r;
  assign mem_if.mem_rev_msg_type_o  = rev_type_r;
  assign mem_if.mem_rev_addr_o      = rev_addr_r;
  assign mem_if.mem_rev_size_o      = rev_size_r;
  assign mem_if.mem_rev_data_o      = rev_data_r;

  assign timer_irq_o    = timer_irq_r;
  assign software_irq_o = msip_r;
  assign mtime_o        = mtime_r;

endmodule

// File: tb/tb_bp_me_clint_slice.sv
// Directed plus randomized bench for bp_me_clint_slice with a register-level
// reference model of the CLINT.
module tb_bp_me_clint_slice;

  localparam int PW = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rtc = 1'b0;
  logic        timer_irq;
  logic        sw_irq;
  logic [63:0] mtime;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_mtime;
  logic [63:0] m_mtimecmp;
  logic        m_msip;

  bp_me_clint_slice_if #(.paddr_width_p(PW)) mem_if ();

  bp_me_clint_slice #(.paddr_width_p(PW), .data_width_p(64)) dut (
    .clk_i          (clk),
    .reset_i        (reset_n),
    .rtc_i          (rtc),
    .mem_if         (mem_if),
    .timer_irq_o    (timer_irq),
    .software_irq_o (sw_irq),
    .mtime_o        (mtime)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_read(input logic [1:0] t, input logic [PW-1:0] a,
                                           input logic [2:0] s);
    logic [63:0] v;
    logic [31:0] h;
    if (t != 2'd0) return 64'd0;
    case (a[15:0] & 16'hFFF8)
      16'h0000: v = {63'd0, m_msip};
      16'h4000: v = m_mtimecmp;
      16'hBFF8: v = m_mtime;
      default:  v = 64'd0;
    endcase
    if (s == 3'd2) begin
      h = a[2] ? v[63:32] : v[31:0];
      return {h, h};
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_merge(input logic [63:0] old_v, input logic [PW-1:0] a,
                                            input logic [2:0] s, input logic [63:0] d);
    if (s != 3'd2) return d;
    return a[2] ? {d[31:0], old_v[31:0]} : {old_v[63:32], d[31:0]};
  endfunction

  task automatic ref_write(input logic [PW-1:0] a, input logic [2:0] s, input logic [63:0] d);
    logic [63:0] tmp;
    case (a[15:0] & 16'hFFF8)
      16'h0000: begin
        tmp = ref_merge({63'd0, m_msip}, a, s, d);
        m_msip = tmp[0];
      end
      16'h4000: m_mtimecmp = ref_merge(m_mtimecmp, a, s, d);
      16'hBFF8: m_mtime = ref_merge(m_mtime, a, s, d);
      default: ;
    endcase
  endtask

  task automatic set_fwd(input logic [1:0] t, input logic [PW-1:0] a, input logic [2:0] s,
                         input logic [63:0] d);
    mem_if.mem_fwd_msg_type_i = t;
    mem_if.mem_fwd_addr_i     = a;
    mem_if.mem_fwd_size_i     = s;
    mem_if.mem_fwd_data_i     = d;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_mtime"}, mtime, m_mtime);
    check({tag, "_timer_irq"}, {63'd0, timer_irq}, {63'd0, (m_mtime >= m_mtimecmp)});
    check({tag, "_sw_irq"}, {63'd0, sw_irq}, {63'd0, m_msip});
  endtask

  task automatic do_txn(input string tag, input logic [1:0] t, input logic [PW-1:0] a,
                        input logic [2:0] s, input logic [63:0] d, input int stall);
    logic [63:0] exp_data;
    int n;
    set_fwd(t, a, s, d);
    mem_if.mem_fwd_v_i = 1'b1;
    n = 0;
    while (mem_if.mem_fwd_ready_and_o !== 1'b1 && n < 20) begin
      tick_clk();
      n++;
    end
    if (n >= 20) check({tag, "_fwd_ready_timeout"}, {63'd0, mem_if.mem_fwd_ready_and_o}, 64'd1);
    exp_data = ref_read(t, a, s);
    tick_clk();
    mem_if.mem_fwd_v_i = 1'b0;
    if (t == 2'd1) ref_write(a, s, d);
    check({tag, "_rev_v"}, {63'd0, mem_if.mem_rev_v_o}, 64'd1);
    check({tag, "_fwd_ready_busy"}, {63'd0, mem_if.mem_fwd_ready_and_o}, 64'd0);
    check({tag, "_rev_type"}, {62'd0, mem_if.mem_rev_msg_type_o}, {62'd0, t});
    check({tag, "_rev_addr"}, {24'd0, mem_if.mem_rev_addr_o}, {24'd0, a});
    check({tag, "_rev_size"}, {61'd0, mem_if.mem_rev_size_o}, {61'd0, s});
    check({tag, "_rev_data"}, mem_if.mem_rev_data_o, exp_data);
    for (int i = 0; i < stall; i++) begin
      tick_clk();
      check({tag, "_stall_rev_v"}, {63'd0, mem_if.mem_rev_v_o}, 64'd1);
      check({tag, "_stall_rev_data"}, mem_if.mem_rev_data_o, exp_data);
    end
    mem_if.mem_rev_ready_and_i = 1'b1;
    tick_clk();
    mem_if.mem_rev_ready_and_i = 1'b0;
    check({tag, "_rev_v_done"}, {63'd0, mem_if.mem_rev_v_o}, 64'd0);
    check({tag, "_fwd_ready_back"}, {63'd0, mem_if.mem_fwd_ready_and_o}, 64'd1);
    check_state(tag);
  endtask

  // mtime must step exactly 3 edges after rtc rises; irq follows mtime by one cycle
  task automatic rtc_pulse(input string tag);
    logic [63:0] base, exp_now, exp_prev;
    base = m_mtime;
    exp_prev = base;
    rtc = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick_clk();
      if (k == 4) rtc = 1'b0;
      exp_now = (k >= 3) ? base + 64'd1 : base;
      check({tag, "_mtime_step"}, mtime, exp_now);
      check({tag, "_timer_irq_step"}, {63'd0, timer_irq}, {63'd0, (exp_prev >= m_mtimecmp)});
      exp_prev = exp_now;
    end
    m_mtime = base + 64'd1;
  endtask

  initial begin
    logic [PW-1:0] addr_tbl [8];
    logic [2:0]    size_tbl [4];
    logic [1:0]    t;
    logic [PW-1:0] a;
    logic [2:0]    s;
    logic [63:0]   d;
    logic [23:0]   up;
    int            r;

    addr_tbl = '{40'h0000, 40'h0004, 40'h4000, 40'h4004,
                 40'hBFF8, 40'hBFFC, 40'h1230, 40'h8008};
    size_tbl = '{3'd3, 3'd2, 3'd2, 3'd0};

    mem_if.mem_fwd_v_i         = 1'b0;
    mem_if.mem_rev_ready_and_i = 1'b0;
    set_fwd(2'd0, '0, 3'd3, 64'd0);
    m_mtime    = 64'd0;
    m_mtimecmp = '1;
    m_msip     = 1'b0;

    // Reset state
    repeat (3) tick_clk();
    check("reset_rev_v", {63'd0, mem_if.mem_rev_v_o}, 64'd0);
    check("reset_timer_irq", {63'd0, timer_irq}, 64'd0);
    check("reset_sw_irq", {63'd0, sw_irq}, 64'd0);
    check("reset_mtime", mtime, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick_clk();
    check("post_reset_fwd_ready", {63'd0, mem_if.mem_fwd_ready_and_o}, 64'd1);

    do_txn("rd_mtime", 2'd0, 40'hBFF8, 3'd3, 64'd0, 0);
    do_txn("rd_mtimecmp", 2'd0, 40'h4000, 3'd3, 64'd0, 0);
    check("rd_mtimecmp_ones", 64'hFFFF_FFFF_FFFF_FFFF, m_mtimecmp);

    // Timer compare and RTC ticks
    do_txn("wr_mtimecmp5", 2'd1, 40'h4000, 3'd3, 64'd5, 0);
    for (int p = 0; p < 5; p++) begin
      repeat (4) tick_clk();
      rtc_pulse("rtc");
    end
    check("rtc_mtime5", mtime, 64'd5);
    check("rtc_timer_irq", {63'd0, timer_irq}, 64'd1);

    // Software interrupt via msip bit 0 only
    do_txn("wr_msip1", 2'd1, 40'h0000, 3'd2, 64'h1, 0);
    check("msip_set", {63'd0, sw_irq}, 64'd1);
    do_txn("wr_msip_even", 2'd1, 40'h0000, 3'd2, 64'hDEAD_BEE0, 1);
    check("msip_clr", {63'd0, sw_irq}, 64'd0);
    do_txn("rd_msip", 2'd0, 40'h0000, 3'd2, 64'd0, 0);

    // Response stall: second request must wait
    set_fwd(2'd0, 40'hAB_0000_4000, 3'd3, 64'd0);
    mem_if.mem_fwd_v_i = 1'b1;
    tick_clk();
    set_fwd(2'd1, 40'h0000, 3'd3, 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      check("stall_rev_v", {63'd0, mem_if.mem_rev_v_o}, 64'd1);
      check("stall_fwd_ready", {63'd0, mem_if.mem_fwd_ready_and_o}, 64'd0);
      check("stall_rev_data", mem_if.mem_rev_data_o, m_mtimecmp);
      check("stall_rev_addr", {24'd0, mem_if.mem_rev_addr_o}, 64'hAB_0000_4000);
      check("stall_sw_irq", {63'd0, sw_irq}, 64'd0);
    end
    mem_if.mem_fwd_v_i = 1'b0;
    mem_if.mem_rev_ready_and_i = 1'b1;
    tick_clk();
    mem_if.mem_rev_ready_and_i = 1'b0;
    check("stall_release_rev_v", {63'd0, mem_if.mem_rev_v_o}, 64'd0);
    check_state("stall_release");

    // mtime wrap and write/tick collision
    do_txn("wr_mtime_max", 2'd1, 40'hBFF8, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    repeat (4) tick_clk();
    rtc_pulse("wrap");
    check("wrap_mtime0", mtime, 64'd0);
    repeat (4) tick_clk();
    set_fwd(2'd1, 40'hBFF8, 3'd3, 64'h100);
    rtc = 1'b1;
    tick_clk();
    tick_clk();
    mem_if.mem_fwd_v_i = 1'b1;
    tick_clk();
    mem_if.mem_fwd_v_i = 1'b0;
    m_mtime = 64'h100;
    check("collide_rev_v", {63'd0, mem_if.mem_rev_v_o}, 64'd1);
    check("collide_mtime", mtime, 64'h100);
    mem_if.mem_rev_ready_and_i = 1'b1;
    tick_clk();
    mem_if.mem_rev_ready_and_i = 1'b0;
    rtc = 1'b0;
    repeat (4) tick_clk();
    check_state("collide_after");

    // Randomized traffic against the model (no RTC activity)
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      t = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : 2'($urandom_range(2, 3));
      up = 24'($urandom);
      a = {up, 16'h0000} | addr_tbl[$urandom_range(0, 7)];
      s = size_tbl[$urandom_range(0, 3)];
      d = {32'($urandom), 32'($urandom)};
      do_txn("rand", t, a, s, d, $urandom_range(0, 3));
    end

    // Reset while a response is pending
    do_txn("pre_reset_wr", 2'd1, 40'h0000, 3'd3, 64'h1, 0);
    set_fwd(2'd0, 40'h4000, 3'd3, 64'd0);
    mem_if.mem_fwd_v_i = 1'b1;
    tick_clk();
    mem_if.mem_fwd_v_i = 1'b0;
    check("rst_mid_rev_v_before", {63'd0, mem_if.mem_rev_v_o}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_rev_v_async", {63'd0, mem_if.mem_rev_v_o}, 64'd0);
    m_mtime = 64'd0;
    m_mtimecmp = '1;
    m_msip = 1'b0;
    check_state("rst_mid");
    repeat (2) tick_clk();
    @(negedge clk);
    reset_n = 1'b1;
    tick_clk();
    check("rst_mid_rev_v_after", {63'd0, mem_if.mem_rev_v_o}, 64'd0);
    check("rst_mid_fwd_ready", {63'd0, mem_if.mem_fwd_ready_and_o}, 64'd1);
    do_txn("post_rst_rd", 2'd0, 40'h4000, 3'd3, 64'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
